// File: rtl/wb_pkg.sv
// Shared definitions for the writeback / retire unit: result-select codes and entry layout.
package wb_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RAW_DEF  = 5;

    // Result source select carried with each instruction
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_CSR = 2'b10;

    // Retire-queue entry at the default widths (MSB first: pc down to ex)
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic                gr_we;
        logic [RAW_DEF-1:0]  dest;
        logic [1:0]          sel;
        logic [XLEN_DEF-1:0] result;
        logic                ex;
    } wb_entry_t;

    // Packed entry width for arbitrary datapath / register-address widths
    function automatic int unsigned entry_width(input int unsigned xlen, input int unsigned raw);
        return (2 * xlen) + raw + 4;
    endfunction

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM-stage entry handshake plus register-file write port of the retire unit.
interface wb_retire_unit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
);

    logic            in_valid;
    logic            in_allowin;
    logic [XLEN-1:0] in_pc;
    logic            in_gr_we;
    logic [RAW-1:0]  in_dest;
    logic [1:0]      in_sel;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_mem_result;
    logic [XLEN-1:0] in_csr_result;
    logic            in_ex;

    logic            rf_wready;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    // Pipeline / register-file side
    modport master (
        output in_valid, in_pc, in_gr_we, in_dest, in_sel,
               in_alu_result, in_mem_result, in_csr_result, in_ex,
        input  in_allowin,
        output rf_wready,
        input  rf_we, rf_waddr, rf_wdata
    );

    // Retire unit side
    modport slave (
        input  in_valid, in_pc, in_gr_we, in_dest, in_sel,
               in_alu_result, in_mem_result, in_csr_result, in_ex,
        output in_allowin,
        input  rf_wready,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with a flush input that empties it on the next edge.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && (r_count != '0);

    // Pointers wrap naturally since DEPTH is a power of two; count separates full from empty
    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are qualified by the count so it needs no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback retire unit: queues MEM-stage results, writes the RF in order,
// raises an exception flush and counts retired instructions.
module wb_retire_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RAW   = RAW_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    wb_retire_unit_if.slave          bus,
    output logic [RAW-1:0]           fwd_dest,
    output logic                     fwd_is_load,
    output logic [XLEN-1:0]          fwd_data,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc,
    output logic [63:0]              instret,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [XLEN-1:0]          debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [RAW-1:0]           debug_wb_rf_wnum,
    output logic [XLEN-1:0]          debug_wb_rf_wdata
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = entry_width(XLEN, RAW);

    logic [XLEN-1:0]    w_sel_result;
    logic               w_push;
    logic [ENTRY_W-1:0] w_enq_data;
    logic [ENTRY_W-1:0] w_head_data;
    logic               w_head_valid;
    logic [CNT_W-1:0]   w_count;

    logic [XLEN-1:0]    w_h_pc;
    logic               w_h_gr_we;
    logic [RAW-1:0]     w_h_dest;
    logic [1:0]         w_h_sel;
    logic [XLEN-1:0]    w_h_result;
    logic               w_h_ex;

    logic               w_retire;
    logic               w_flush;
    logic               w_rf_we;
    logic [63:0]        r_instret;

    // Pick the instruction result once, at enqueue time
    always_comb begin
        w_sel_result = bus.in_alu_result;
        case (bus.in_sel)
            SEL_ALU: w_sel_result = bus.in_alu_result;
            SEL_MEM: w_sel_result = bus.in_mem_result;
            SEL_CSR: w_sel_result = bus.in_csr_result;
            default: w_sel_result = bus.in_alu_result;
        endcase
    end

    // Acceptance depends only on the registered count, never on rf_wready
    assign bus.in_allowin = (w_count < CNT_W'(DEPTH));
    assign w_push         = bus.in_valid && bus.in_allowin;
    assign w_enq_data     = {bus.in_pc, bus.in_gr_we, bus.in_dest, bus.in_sel,
                             w_sel_result, bus.in_ex};

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata (w_enq_data),
        .i_pop   (w_retire),
        .i_flush (w_flush),
        .o_rdata (w_head_data),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    assign {w_h_pc, w_h_gr_we, w_h_dest, w_h_sel, w_h_result, w_h_ex} = w_head_data;

    // Head leaves on an exception, when it has nothing to write, or when the RF grants
    assign w_retire = w_head_valid && (w_h_ex || !w_h_gr_we || bus.rf_wready);
    assign w_flush  = w_head_valid && w_h_ex;
    assign w_rf_we  = w_head_valid && w_h_gr_we && !w_h_ex;

    // Count every retire that is not an exception, wrapping at 2^64
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_instret <= '0;
        end else if (w_retire && !w_h_ex) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign bus.rf_we    = w_rf_we;
    assign bus.rf_waddr = w_h_dest;
    assign bus.rf_wdata = w_h_result;

    assign fwd_dest     = w_rf_we ? w_h_dest : RAW'(0);
    assign fwd_is_load  = w_head_valid && (w_h_sel == SEL_MEM);
    assign fwd_data     = w_h_result;

    assign flush        = w_flush;
    assign flush_pc     = w_flush ? w_h_pc : XLEN'(0);
    assign instret      = r_instret;
    assign occupancy    = w_count;

    assign debug_wb_pc       = w_h_pc;
    assign debug_wb_rf_we    = {4{w_rf_we && bus.rf_wready}};
    assign debug_wb_rf_wnum  = w_h_dest;
    assign debug_wb_rf_wdata = w_h_result;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed scenarios with literal checks, plus a
// queue-level reference model compared against the outputs every cycle.
module tb_wb_retire_unit;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    logic [RAW-1:0]  fwd_dest;
    logic            fwd_is_load;
    logic [XLEN-1:0] fwd_data;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic [63:0]     instret;
    logic [1:0]      occupancy;
    logic [XLEN-1:0] debug_wb_pc;
    logic [3:0]      debug_wb_rf_we;
    logic [RAW-1:0]  debug_wb_rf_wnum;
    logic [XLEN-1:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_retire_unit_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

    wb_retire_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RAW(RAW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .bus               (bus),
        .fwd_dest          (fwd_dest),
        .fwd_is_load       (fwd_is_load),
        .fwd_data          (fwd_data),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .instret           (instret),
        .occupancy         (occupancy),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [1:0]  sel;
        logic [31:0] res;
        logic        ex;
    } ment_t;

    ment_t       mq[$];
    logic [63:0] m_instret = '0;
    logic        m_ready   = 1'b0;

    function automatic logic [31:0] sel_res(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] m, input logic [31:0] c);
        if (s == 2'd1) return m;
        if (s == 2'd2) return c;
        return a;
    endfunction

    // Compare against the model mid-cycle, then advance the model to the next edge
    always @(negedge clk) begin
        ment_t h;
        ment_t e;
        logic  hv;
        logic  ewe;
        logic  acc;
        hv  = (mq.size() != 0);
        h   = '{default: '0};
        if (hv) h = mq[0];
        ewe = hv && h.gr_we && !h.ex;
        if (m_ready) begin
            chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
            chk("m_allowin", 64'(bus.in_allowin), 64'(mq.size() < DEPTH));
            chk("m_rf_we", 64'(bus.rf_we), 64'(ewe));
            chk("m_fwd_dest", 64'(fwd_dest), ewe ? 64'(h.dest) : 64'd0);
            chk("m_flush", 64'(flush), 64'(hv && h.ex));
            chk("m_dbg_we", 64'(debug_wb_rf_we), (ewe && bus.rf_wready) ? 64'hf : 64'h0);
            chk("m_instret", instret, m_instret);
            if (ewe) begin
                chk("m_waddr", 64'(bus.rf_waddr), 64'(h.dest));
                chk("m_wdata", 64'(bus.rf_wdata), 64'(h.res));
            end
            if (hv && h.ex) chk("m_flush_pc", 64'(flush_pc), 64'(h.pc));
            if (hv) begin
                chk("m_fwd_data", 64'(fwd_data), 64'(h.res));
                chk("m_fwd_is_load", 64'(fwd_is_load), 64'(h.sel == 2'd1));
                chk("m_dbg_pc", 64'(debug_wb_pc), 64'(h.pc));
                chk("m_dbg_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
                chk("m_dbg_wdata", 64'(debug_wb_rf_wdata), 64'(h.res));
            end
        end
        if (!resetn) begin
            mq.delete();
            m_instret = '0;
            m_ready   = 1'b1;
        end else if (m_ready) begin
            acc = bus.in_valid && (mq.size() < DEPTH);
            if (hv && h.ex) begin
                mq.delete();
            end else begin
                if (hv && (!h.gr_we || bus.rf_wready)) begin
                    void'(mq.pop_front());
                    m_instret = m_instret + 64'd1;
                end
                if (acc) begin
                    e.pc    = bus.in_pc;
                    e.gr_we = bus.in_gr_we;
                    e.dest  = bus.in_dest;
                    e.sel   = bus.in_sel;
                    e.res   = sel_res(bus.in_sel, bus.in_alu_result, bus.in_mem_result, bus.in_csr_result);
                    e.ex    = bus.in_ex;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic we, input logic [4:0] dest, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] csr, input logic ex);
        bus.in_valid      = v;
        bus.in_gr_we      = we;
        bus.in_dest       = dest;
        bus.in_sel        = sel;
        bus.in_pc         = pc;
        bus.in_alu_result = alu;
        bus.in_mem_result = mem;
        bus.in_csr_result = csr;
        bus.in_ex         = ex;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        idle();
        bus.rf_wready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        // Reset state
        chk("rst_allowin", 64'(bus.in_allowin), 64'd1);
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_fwd_dest", 64'(fwd_dest), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_instret", instret, 64'd0);

        // Single enqueue, visible one cycle later
        put(1'b1, 1'b1, 5'd3, 2'b00, 32'h1c000000, 32'h55, 32'h0, 32'h0, 1'b0);
        bus.rf_wready = 1'b1;
        tick();
        idle();
        chk("single_we", 64'(bus.rf_we), 64'd1);
        chk("single_waddr", 64'(bus.rf_waddr), 64'd3);
        chk("single_wdata", 64'(bus.rf_wdata), 64'h55);
        chk("single_fwd_dest", 64'(fwd_dest), 64'd3);
        tick();
        chk("single_instret", instret, 64'd1);
        chk("single_occ", 64'(occupancy), 64'd0);

        // Back-pressure: third entry held while full, then in-order drain
        bus.rf_wready = 1'b0;
        put(1'b1, 1'b1, 5'd5, 2'b00, 32'h1c000004, 32'h11, 32'h0, 32'h0, 1'b0);
        tick();
        put(1'b1, 1'b1, 5'd6, 2'b00, 32'h1c000008, 32'h22, 32'h0, 32'h0, 1'b0);
        tick();
        put(1'b1, 1'b1, 5'd7, 2'b00, 32'h1c00000c, 32'h33, 32'h0, 32'h0, 1'b0);
        chk("full_allowin", 64'(bus.in_allowin), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_waddr", 64'(bus.rf_waddr), 64'd5);
        tick();
        chk("held_occ", 64'(occupancy), 64'd2);
        chk("held_we", 64'(bus.rf_we), 64'd1);
        bus.rf_wready = 1'b1;
        tick();
        chk("drain1_occ", 64'(occupancy), 64'd1);
        chk("drain1_waddr", 64'(bus.rf_waddr), 64'd6);
        tick();
        idle();
        chk("drain2_occ", 64'(occupancy), 64'd1);
        chk("drain2_waddr", 64'(bus.rf_waddr), 64'd7);
        chk("drain2_wdata", 64'(bus.rf_wdata), 64'h33);
        tick();
        chk("drain3_occ", 64'(occupancy), 64'd0);
        chk("drain3_instret", instret, 64'd4);

        // Exception at head with a concurrent entry arriving
        bus.rf_wready = 1'b0;
        put(1'b1, 1'b1, 5'd10, 2'b00, 32'h1c000030, 32'ha0, 32'h0, 32'h0, 1'b0);
        tick();
        put(1'b1, 1'b1, 5'd8, 2'b00, 32'h1c000040, 32'hbad, 32'h0, 32'h0, 1'b1);
        tick();
        put(1'b1, 1'b1, 5'd9, 2'b00, 32'h1c000044, 32'h99, 32'h0, 32'h0, 1'b0);
        bus.rf_wready = 1'b1;
        chk("ex_pre_occ", 64'(occupancy), 64'd2);
        chk("ex_pre_flush", 64'(flush), 64'd0);
        tick();
        chk("ex_flush", 64'(flush), 64'd1);
        chk("ex_flush_pc", 64'(flush_pc), 64'h1c000040);
        chk("ex_rf_we", 64'(bus.rf_we), 64'd0);
        chk("ex_dbg_we", 64'(debug_wb_rf_we), 64'd0);
        chk("ex_instret", instret, 64'd5);
        tick();
        idle();
        chk("post_flush_occ", 64'(occupancy), 64'd0);
        chk("post_flush_flush", 64'(flush), 64'd0);
        chk("post_flush_instret", instret, 64'd5);
        chk("post_flush_allowin", 64'(bus.in_allowin), 64'd1);

        // Result select: mem, csr, alu(11)
        put(1'b1, 1'b1, 5'd11, 2'b01, 32'h1c000100, 32'h1, 32'hdead, 32'h2, 1'b0);
        tick();
        put(1'b1, 1'b1, 5'd12, 2'b10, 32'h1c000104, 32'h1, 32'h3, 32'hbeef, 1'b0);
        chk("sel_mem_wdata", 64'(bus.rf_wdata), 64'hdead);
        chk("sel_mem_load", 64'(fwd_is_load), 64'd1);
        chk("sel_mem_waddr", 64'(bus.rf_waddr), 64'd11);
        tick();
        put(1'b1, 1'b1, 5'd13, 2'b11, 32'h1c000108, 32'h7, 32'h4, 32'h5, 1'b0);
        chk("sel_csr_wdata", 64'(bus.rf_wdata), 64'hbeef);
        chk("sel_csr_load", 64'(fwd_is_load), 64'd0);
        tick();
        idle();
        chk("sel_alu_wdata", 64'(bus.rf_wdata), 64'h7);
        chk("sel_alu_load", 64'(fwd_is_load), 64'd0);
        tick();
        chk("sel_instret", instret, 64'd8);

        // No-write entries stream at full rate without a grant
        bus.rf_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1'b0, 5'(20 + i), 2'b00, 32'h1c000200 + 32'(4 * i), 32'(i), 32'h0, 32'h0, 1'b0);
            tick();
            chk("nowr_occ", 64'(occupancy), 64'd1);
            chk("nowr_fwd_dest", 64'(fwd_dest), 64'd0);
            chk("nowr_instret", instret, 64'(8 + i));
        end
        idle();
        tick();
        chk("nowr_end_instret", instret, 64'd12);
        chk("nowr_end_occ", 64'(occupancy), 64'd0);

        // Reset with a full queue
        put(1'b1, 1'b1, 5'd14, 2'b00, 32'h1c000300, 32'h14, 32'h0, 32'h0, 1'b0);
        tick();
        put(1'b1, 1'b1, 5'd15, 2'b00, 32'h1c000304, 32'h15, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        chk("prerst_occ", 64'(occupancy), 64'd2);
        resetn = 1'b0;
        tick();
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("midrst_instret", instret, 64'd0);
        chk("midrst_flush", 64'(flush), 64'd0);
        chk("midrst_allowin", 64'(bus.in_allowin), 64'd1);
        resetn = 1'b1;
        tick();
        tick();
        chk("end_occ", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_retire_unit.md
WB_RETIRE_UNIT -- requirements
Module: wb_retire_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter DEPTH, default 2, retire-queue entries (power of 2, 2..8).
REQ-003 SHALL have parameter RAW, default 5, register-address width.
REQ-004 Ports (clock and reset first):
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- in_valid  in  1  MEM-stage entry valid.
- in_allowin  out  1  queue can accept an entry.
- in_pc  in  XLEN  instruction PC.
- in_gr_we  in  1  instruction writes the RF.
- in_dest  in  RAW  destination register.
- in_sel  in  2  result source select.
- in_alu_result / in_mem_result / in_csr_result  in  XLEN each  candidate results.
- in_ex  in  1  instruction carries an exception.
- rf_wready  in  1  RF write port granted this cycle.
- rf_we  out  1  RF write request.
- rf_waddr  out  RAW  RF write address.
- rf_wdata  out  XLEN  RF write data.
- fwd_dest  out  RAW  forwarding destination (0 = none).
- fwd_is_load  out  1  head result comes from memory.
- fwd_data  out  XLEN  forwarding data.
- flush  out  1  exception flush pulse.
- flush_pc  out  XLEN  PC of the excepting instruction.
- instret  out  64  retired-instruction count.
- occupancy  out  $clog2(DEPTH)+1  valid entries held.
- debug_wb_pc  out  XLEN; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  RAW; debug_wb_rf_wdata  out  XLEN  trace.

Function
REQ-005 SHALL enqueue {pc,gr_we,dest,sel,selected result,ex} when in_valid && in_allowin; result selected at enqueue: sel 00 alu, 01 mem, 10 csr, 11 alu.
REQ-006 SHALL drive in_allowin = (occupancy < DEPTH), registered state only, with no combinational path from rf_wready.
REQ-007 Head SHALL retire when valid and any of: in_ex set; gr_we clear; rf_wready high.
REQ-008 SHALL drive rf_we = head_valid && gr_we && !ex; rf_waddr/rf_wdata from head; rf_we holds with stable data while rf_wready low.
REQ-009 Simultaneous enqueue and retire SHALL leave occupancy unchanged; enqueue into a full queue SHALL be impossible even if the head retires that cycle.
REQ-010 Pointers SHALL wrap modulo DEPTH; occupancy distinguishes full from empty.
REQ-011 Head retiring with ex set SHALL assert flush for exactly that cycle with flush_pc = head pc, SHALL NOT write the RF, and SHALL NOT increment instret.
REQ-012 On the cycle after flush, all entries SHALL be invalid (occupancy 0); any entry enqueued in the flush cycle SHALL be discarded.
REQ-013 instret SHALL increment by 1 for each non-exception retire, including gr_we=0; it SHALL wrap at 2^64.
REQ-014 fwd_dest SHALL be head dest when rf_we is asserted, else 0; fwd_data = head result; fwd_is_load = head sel==01.
REQ-015 debug_wb_rf_we SHALL be {4{rf_we && rf_wready}}; debug_wb_pc/rf_wnum/rf_wdata from head.
REQ-016 Latency SHALL be 1 cycle: entry enqueued at edge N is head-visible in cycle N+1 if queue was empty.

Reset
REQ-017 While resetn low at a clk edge: pointers, occupancy, valids, and instret SHALL clear to 0, and flush SHALL clear to 0.
REQ-018 After reset: in_allowin=1, rf_we=0, fwd_dest=0, flush_pc=0, debug_wb_rf_we=0.
REQ-019 Reset mid-operation SHALL discard all entries without RF write or flush.

Structure
REQ-020 A shared package wb_pkg SHALL hold the sel encodings (SEL_ALU, SEL_MEM, SEL_CSR), entry struct/width constant, and default XLEN/RAW.
REQ-021 Storage SHALL be a sub-module wb_fifo (generic synchronous FIFO with flush input); the top holds select, retire, flush and counter logic.

Verification
REQ-022 Reset then single enqueue (pc 0x1c000000, dest 3, sel 00, alu 0x55), rf_wready=1 -> next cycle rf_we=1, waddr 3, wdata 0x55; instret=1.
REQ-023 DEPTH=2, rf_wready=0, three back-to-back in_valid -> two accepted, in_allowin=0 and occupancy=2, third held; raising rf_wready drains in order.
REQ-024 Head ex=1 (pc 0x1c000040) with valid entry behind and concurrent in_valid -> flush=1 one cycle, flush_pc 0x1c000040, no rf_we, occupancy 0 next cycle, instret unchanged.
REQ-025 sel 01 mem 0xdead, sel 10 csr 0xbeef, sel 11 alu 0x7 -> rf_wdata 0xdead, 0xbeef, 0x7; fwd_is_load 1, 0, 0.
REQ-026 gr_we=0 entries stream at full rate with rf_wready=0 -> one retire per cycle, fwd_dest=0, instret increments each cycle.
REQ-027 resetn asserted with occupancy=2 -> next cycle occupancy 0, rf_we=0, instret 0, flush 0.
